// File: rtl/abs_diff_accumulator_pkg.sv
// Shared definitions for the SAD accumulator: FSM state encodings, default sizes and a
// constant clog2 used to size the window counter.
package abs_diff_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    localparam int DEF_DIFF_W  = 22;
    localparam int DEF_WIN_LEN = 64;
    localparam int DEF_ACC_W   = 28;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/abs_diff_accumulator_if.sv
// Difference-in / SAD-out stream bundle; the accumulator is the slave on both streams.
interface abs_diff_accumulator_if #(
    parameter int DIFF_W = 22,
    parameter int ACC_W  = 28
);
    logic [DIFF_W-1:0] diff_in;
    logic              diff_valid;
    logic              diff_ready;
    logic [ACC_W-1:0]  sad_out;
    logic              sad_valid;
    logic              sad_ready;
    logic              sat_flag;

    modport master (
        output diff_in, diff_valid, sad_ready,
        input  diff_ready, sad_out, sad_valid, sat_flag
    );

    modport slave (
        input  diff_in, diff_valid, sad_ready,
        output diff_ready, sad_out, sad_valid, sat_flag
    );
endinterface

// File: rtl/abs_diff_accumulator_abs_stage.sv
// Registered |x| of a two's-complement sample; the most negative input maps to its exact
// unsigned magnitude because the result keeps the full DIFF_W bits unsigned.
module abs_diff_accumulator_abs_stage #(
    parameter int DIFF_W = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIFF_W-1:0] x_i,
    input  logic              valid_i,
    output logic [DIFF_W-1:0] abs_o,
    output logic              valid_o
);
    logic [DIFF_W-1:0] abs_q, abs_d;
    logic              valid_q, valid_d;

    // Magnitude of the accepted sample; hold the last value otherwise.
    always_comb begin
        abs_d   = abs_q;
        valid_d = valid_i;
        if (valid_i) begin
            if (x_i[DIFF_W-1]) begin
                abs_d = ~x_i + DIFF_W'(1'b1);
            end else begin
                abs_d = x_i;
            end
        end else begin
            abs_d = abs_q;
        end
    end

    // Stage register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abs_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            abs_q   <= abs_d;
            valid_q <= valid_d;
        end
    end

    assign abs_o   = abs_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/abs_diff_accumulator.sv
// Sum of |diff| over windows of WIN_LEN samples, streamed out with valid/ready.
// Define SATURATE_EN to clamp the sum at all-ones and raise a sticky sat_flag.
module abs_diff_accumulator
    import abs_diff_accumulator_pkg::*;
#(
    parameter int DIFF_W  = DEF_DIFF_W,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int CNT_W   = clog2(WIN_LEN) + 1
) (
    input logic              clk,
    input logic              rst_n,
    abs_diff_accumulator_if.slave bus
);
`ifdef SATURATE_EN
    localparam int SUM_W = ((ACC_W > DIFF_W) ? ACC_W : DIFF_W) + 1;
`else
    localparam int SUM_W = ACC_W;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;
    logic              diff_ready_q, diff_ready_d;
    logic              sad_valid_q, sad_valid_d;
    logic [ACC_W-1:0]  sad_out_q, sad_out_d;
    logic              accept_s, handshake_s, last_s, abs_v_s;
    logic [DIFF_W-1:0] abs_s;
    logic [SUM_W-1:0]  sum_s;

    assign accept_s    = bus.diff_valid && diff_ready_q;
    assign handshake_s = sad_valid_q && bus.sad_ready;
    assign last_s      = (cnt_q == CNT_W'(WIN_LEN - 1));
    assign sum_s       = SUM_W'(acc_q) + SUM_W'(abs_s);

    abs_diff_accumulator_abs_stage #(.DIFF_W(DIFF_W)) u_abs_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_i     (bus.diff_in),
        .valid_i (accept_s),
        .abs_o   (abs_s),
        .valid_o (abs_v_s)
    );

    // State, counter, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_ACCUM;
            cnt_q        <= '0;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            diff_ready_q <= 1'b0;
            sad_valid_q  <= 1'b0;
            sad_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            diff_ready_q <= diff_ready_d;
            sad_valid_q  <= sad_valid_d;
            sad_out_q    <= sad_out_d;
        end
    end

    // Next state and window counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept_s) begin
                    cnt_d   = cnt_q + CNT_W'(1'b1);
                    state_d = last_s ? ST_DRAIN : ST_ACCUM;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (handshake_s) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            default: begin
                state_d = ST_ACCUM;
                cnt_d   = '0;
            end
        endcase
    end

    // Accumulate the registered magnitude; cleared when the result is taken.
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (handshake_s) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (abs_v_s) begin
`ifdef SATURATE_EN
            if (|sum_s[SUM_W-1:ACC_W]) begin
                acc_d = '1;
                sat_d = 1'b1;
            end else begin
                acc_d = sum_s[ACC_W-1:0];
                sat_d = sat_q;
            end
`else
            acc_d = sum_s[ACC_W-1:0];
            sat_d = 1'b0;
`endif
        end else begin
            acc_d = acc_q;
            sat_d = sat_q;
        end
    end

    // Outputs: the result is captured on entry to OUTPUT, so sad_valid rises one cycle later.
    always_comb begin
        diff_ready_d = (state_d == ST_ACCUM);
        sad_valid_d  = (state_q == ST_OUTPUT) && !handshake_s;
        if ((state_q == ST_OUTPUT) && !sad_valid_q) begin
            sad_out_d = acc_q;
        end else begin
            sad_out_d = sad_out_q;
        end
    end

    assign bus.diff_ready = diff_ready_q;
    assign bus.sad_valid  = sad_valid_q;
    assign bus.sad_out    = sad_out_q;
    assign bus.sat_flag   = sat_q;
endmodule

// File: tb/tb_abs_diff_accumulator.sv
// Bench for abs_diff_accumulator: three configurations share one stimulus stream and are
// scored against a window-sum model; directed cases check the documented example results.
`timescale 1ns/1ps
module tb_abs_diff_accumulator;
    localparam int DW = 22;
    localparam int NI = 3;
    localparam int WIN_A = 4, WIN_B = 2, WIN_C = 4;
    localparam int ACC_A = 28, ACC_B = 28, ACC_C = 8;
    localparam int LIMIT = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] diff_in = '0;
    logic          diff_valid = 1'b0;
    logic          sad_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    abs_diff_accumulator_if #(.DIFF_W(DW), .ACC_W(ACC_A)) if_a ();
    abs_diff_accumulator_if #(.DIFF_W(DW), .ACC_W(ACC_B)) if_b ();
    abs_diff_accumulator_if #(.DIFF_W(DW), .ACC_W(ACC_C)) if_c ();

    assign if_a.diff_in = diff_in;  assign if_a.diff_valid = diff_valid;  assign if_a.sad_ready = sad_ready;
    assign if_b.diff_in = diff_in;  assign if_b.diff_valid = diff_valid;  assign if_b.sad_ready = sad_ready;
    assign if_c.diff_in = diff_in;  assign if_c.diff_valid = diff_valid;  assign if_c.sad_ready = sad_ready;

    abs_diff_accumulator #(.DIFF_W(DW), .WIN_LEN(WIN_A), .ACC_W(ACC_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    abs_diff_accumulator #(.DIFF_W(DW), .WIN_LEN(WIN_B), .ACC_W(ACC_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    abs_diff_accumulator #(.DIFF_W(DW), .WIN_LEN(WIN_C), .ACC_W(ACC_C)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    logic [NI-1:0] rdy, sv, sf;
    logic [63:0]   so [NI];
    assign rdy[0] = if_a.diff_ready;  assign sv[0] = if_a.sad_valid;  assign sf[0] = if_a.sat_flag;
    assign rdy[1] = if_b.diff_ready;  assign sv[1] = if_b.sad_valid;  assign sf[1] = if_b.sat_flag;
    assign rdy[2] = if_c.diff_ready;  assign sv[2] = if_c.sad_valid;  assign sf[2] = if_c.sat_flag;
    assign so[0] = 64'(if_a.sad_out);
    assign so[1] = 64'(if_b.sad_out);
    assign so[2] = 64'(if_c.sad_out);

    // Reference model: per-instance running window and at most one finished window awaiting output.
    int     win_len [NI] = '{WIN_A, WIN_B, WIN_C};
    int     acc_w   [NI] = '{ACC_A, ACC_B, ACC_C};
    longint sum_m   [NI];
    int     cnt_m   [NI];
    bit     sat_m   [NI];
    bit     pend    [NI];
    longint pend_sum[NI];
    bit     pend_sat[NI];
    int     last_acc_cyc[NI];
    int     low_cnt [NI];
    bit     any_win [NI];
    int     done_m  [NI] = '{0, 0, 0};
    longint last_sad[NI];
    bit     last_sat[NI];
    bit     rst_prev = 1'b0;
    bit     gap_chk = 1'b0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        longint a;
        longint lim;
        for (int k = 0; k < NI; k++) begin
            if (!rst_prev) begin
                check_val($sformatf("rst_ready_%0d", k), rdy[k], 0);
                check_val($sformatf("rst_valid_%0d", k), sv[k], 0);
                check_val($sformatf("rst_sad_%0d", k), so[k], 0);
                check_val($sformatf("rst_sat_%0d", k), sf[k], 0);
            end else begin
                check_val($sformatf("sad_valid_%0d", k), sv[k],
                          (pend[k] && (cyc >= last_acc_cyc[k] + 2)) ? 1 : 0);
                check_val($sformatf("diff_ready_%0d", k), rdy[k], pend[k] ? 0 : 1);
                if (sv[k] && pend[k]) begin
                    check_val($sformatf("sad_out_%0d", k), so[k], pend_sum[k]);
                    check_val($sformatf("sat_flag_%0d", k), sf[k], pend_sat[k]);
                end
            end

            if (!rst_n) begin
                sum_m[k] = 0; cnt_m[k] = 0; sat_m[k] = 0; pend[k] = 0;
                low_cnt[k] = 0; any_win[k] = 0;
            end else begin
                if (sv[k] && sad_ready && pend[k]) begin
                    pend[k]     = 0;
                    last_sad[k] = so[k];
                    last_sat[k] = sf[k];
                    done_m[k]++;
                end
                if (diff_valid && rdy[k]) begin
                    if (cnt_m[k] == 0 && any_win[k] && gap_chk)
                        check_val($sformatf("bubble_%0d", k), low_cnt[k], 3);
                    low_cnt[k] = 0;
                    a = longint'($signed(diff_in));
                    if (a < 0) a = -a;
                    lim = (longint'(1) << acc_w[k]) - 1;
                    sum_m[k] = sum_m[k] + a;
`ifdef SATURATE_EN
                    if (sum_m[k] > lim) begin
                        sum_m[k] = lim;
                        sat_m[k] = 1;
                    end
`else
                    sum_m[k] = sum_m[k] & lim;
`endif
                    cnt_m[k]++;
                    if (cnt_m[k] == win_len[k]) begin
                        pend[k] = 1; pend_sum[k] = sum_m[k]; pend_sat[k] = sat_m[k];
                        last_acc_cyc[k] = cyc + 1;
                        any_win[k] = 1;
                        cnt_m[k] = 0; sum_m[k] = 0; sat_m[k] = 0;
                    end
                end else if (!rdy[k]) begin
                    low_cnt[k]++;
                end
            end
        end
        rst_prev = rst_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        diff_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input int k, input int d);
        int n;
        n = 0;
        diff_in = DW'(d);
        diff_valid = 1'b1;
        while (!rdy[k] && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) check_val($sformatf("send_timeout_%0d", k), rdy[k], 1);
        tick();
    endtask

    task automatic wait_done(input int k, input int tgt);
        int n;
        n = 0;
        while (done_m[k] < tgt && n < LIMIT) begin
            tick();
            n++;
        end
        if (done_m[k] < tgt) check_val($sformatf("result_timeout_%0d", k), done_m[k], tgt);
    endtask

    function automatic int rand_diff();
        int r;
        r = int'($urandom_range(0, 7));
        case (r)
            0:       return -2097152;
            1:       return 2097151;
            2, 3:    return int'($urandom_range(0, 40)) - 20;
            default: return int'($urandom_range(0, 4194303)) - 2097152;
        endcase
    endfunction

    initial begin
        int tgt;
        do_reset();

        // Small mixed-sign window, consumer always ready.
        sad_ready = 1'b1;
        tgt = done_m[0] + 1;
        send(0, 3); send(0, -5); send(0, 0); send(0, -1);
        diff_valid = 1'b0;
        wait_done(0, tgt);
        check_val("t1_sad", last_sad[0], 9);
        check_val("t1_ready_low", low_cnt[0], 3);

        // Most negative difference, two-sample window.
        do_reset();
        tgt = done_m[1] + 1;
        send(1, -2097152); send(1, -2097152);
        diff_valid = 1'b0;
        wait_done(1, tgt);
        check_val("t2_sad", last_sad[1], 4194304);

        // Back-pressure: hold the result for 10 cycles with random valid traffic.
        do_reset();
        sad_ready = 1'b0;
        for (int n = 0; n < LIMIT && !pend[0]; n++) begin
            diff_valid = 1'($urandom_range(0, 1));
            diff_in = DW'(rand_diff());
            tick();
        end
        for (int n = 0; n < 10; n++) begin
            diff_valid = 1'($urandom_range(0, 1));
            diff_in = DW'(rand_diff());
            tick();
        end
        check_val("t3_held_valid", sv[0], 1);
        sad_ready = 1'b1;
        tgt = done_m[0] + 2;
        for (int n = 0; n < LIMIT && done_m[0] < tgt; n++) begin
            diff_valid = 1'($urandom_range(0, 1));
            diff_in = DW'(rand_diff());
            tick();
        end
        check_val("t3_windows", done_m[0], tgt);

        // Reset in the middle of a window, then a clean window of ones.
        do_reset();
        send(0, 1); send(0, 1); send(0, 1);
        rst_n = 1'b0;
        diff_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tgt = done_m[0] + 1;
        send(0, 1); send(0, 1); send(0, 1); send(0, 1);
        diff_valid = 1'b0;
        wait_done(0, tgt);
        check_val("t4_sad", last_sad[0], 4);

        // Overflow of the narrow accumulator.
        do_reset();
        tgt = done_m[2] + 1;
        send(2, 100); send(2, 100); send(2, 100); send(2, -100);
        diff_valid = 1'b0;
        wait_done(2, tgt);
`ifdef SATURATE_EN
        check_val("t5_sad", last_sad[2], 255);
        check_val("t5_sat", last_sat[2], 1);
`else
        check_val("t5_sad", last_sad[2], 144);
        check_val("t5_sat", last_sat[2], 0);
`endif

        // Consecutive windows at full rate: one fixed bubble between windows.
        do_reset();
        gap_chk = 1'b1;
        diff_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            diff_in = DW'(rand_diff());
            tick();
        end
        gap_chk = 1'b0;

        // Long random traffic with random back-pressure.
        for (int n = 0; n < 1500; n++) begin
            diff_valid = ($urandom_range(0, 3) != 0);
            sad_ready  = ($urandom_range(0, 2) != 0);
            diff_in    = DW'(rand_diff());
            tick();
        end
        diff_valid = 1'b0;
        sad_ready = 1'b1;
        for (int n = 0; n < 20; n++) tick();
        check_val("drain_a", pend[0], 0);
        check_val("drain_b", pend[1], 0);
        check_val("drain_c", pend[2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
